// File: rtl/fifo_pkg.sv
// Shared constants for the synchronous FIFO: default geometry, flag-threshold
// defaults and the depth helper used to size counters.
package fifo_pkg;

    localparam int DEF_DATA_WIDTH    = 16;
    localparam int DEF_ADDR_BITS     = 10;
    localparam int DEF_AFULL_MARGIN  = 4;
    localparam int DEF_AEMPTY_THRESH = 4;

    function automatic int fifo_depth(input int addr_bits);
        return 1 << addr_bits;
    endfunction

    function automatic int count_width(input int addr_bits);
        return addr_bits + 1;
    endfunction

endpackage

// File: rtl/fifo_sdp_ram.sv
// Simple dual-port storage: one write port and one registered read port.
// The array has no reset; contents persist across reset and flush.
module fifo_sdp_ram #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_BITS  = 10
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_BITS-1:0]  wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_BITS-1:0]  rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [0:(1<<ADDR_BITS)-1];

    // A read of the address being written in the same cycle returns the old word.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
        if (rd_en) rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with count, status flags and rejected-request pulses.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through output; default is registered read.
module sync_fifo
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
    parameter int ADDR_BITS     = DEF_ADDR_BITS,
    parameter int AFULL_THRESH  = fifo_depth(ADDR_BITS) - DEF_AFULL_MARGIN,
    parameter int AEMPTY_THRESH = DEF_AEMPTY_THRESH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  wr_req,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  rd_req,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_valid,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_BITS:0]    usedw,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int CW = count_width(ADDR_BITS);
    localparam logic [CW-1:0]        DEPTH_W = CW'(fifo_depth(ADDR_BITS));
    localparam logic [CW-1:0]        AF_W    = CW'(AFULL_THRESH);
    localparam logic [CW-1:0]        AE_W    = CW'(AEMPTY_THRESH);
    localparam logic [CW-1:0]        CNT_ONE = CW'(1);
    localparam logic [ADDR_BITS-1:0] PTR_ONE = ADDR_BITS'(1);

    logic                  wr_en, rd_en;
    logic [ADDR_BITS-1:0]  wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt;
    logic [CW-1:0]         usedw_nxt;
    logic                  ram_rd_en;
    logic [ADDR_BITS-1:0]  ram_rd_addr;
    logic [DATA_WIDTH-1:0] ram_q;

    // Request/accept: a write is taken on a rising edge where wr_req=1 and full=0,
    // a read where rd_req=1 and empty=0; flush wins over both. A request that is
    // refused reports as a one-cycle overflow/underflow pulse on the next cycle.
    always_comb begin
        wr_en      = wr_req && !full && !flush;
        rd_en      = rd_req && !empty && !flush;
        wr_ptr_nxt = wr_en ? wr_ptr + PTR_ONE : wr_ptr;
        rd_ptr_nxt = rd_en ? rd_ptr + PTR_ONE : rd_ptr;
        usedw_nxt  = usedw;
        case ({wr_en, rd_en})
            2'b10:   usedw_nxt = usedw + CNT_ONE;
            2'b01:   usedw_nxt = usedw - CNT_ONE;
            default: usedw_nxt = usedw;
        endcase
        if (flush) begin
            wr_ptr_nxt = '0;
            rd_ptr_nxt = '0;
            usedw_nxt  = '0;
        end
    end

    // Flags are registered from the next count so they always agree with usedw.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            usedw        <= '0;
            full         <= 1'b0;
            empty        <= 1'b1;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            wr_ptr       <= wr_ptr_nxt;
            rd_ptr       <= rd_ptr_nxt;
            usedw        <= usedw_nxt;
            full         <= (usedw_nxt == DEPTH_W);
            empty        <= (usedw_nxt == '0);
            almost_full  <= (usedw_nxt >= AF_W);
            almost_empty <= (usedw_nxt <= AE_W);
            overflow     <= wr_req && full && !flush;
            underflow    <= rd_req && empty && !flush;
        end
    end

`ifdef SYNC_FIFO_FWFT_EN
    logic stale;

    // The RAM continuously fetches the next head; a write landing on that address
    // in the same cycle leaves the fetched word old for one cycle.
    assign ram_rd_en   = 1'b1;
    assign ram_rd_addr = rd_ptr_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) stale <= 1'b0;
        else        stale <= wr_en && (wr_ptr == rd_ptr_nxt);
    end

    assign data_valid = !empty && !stale;
    assign data_out   = data_valid ? ram_q : '0;
`else
    logic loaded;

    assign ram_rd_en   = rd_en;
    assign ram_rd_addr = rd_ptr;

    // Output holds the RAM read register, masked to zero until the first read after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_valid <= 1'b0;
            loaded     <= 1'b0;
        end else begin
            data_valid <= rd_en;
            loaded     <= loaded || rd_en;
        end
    end

    assign data_out = loaded ? ram_q : '0;
`endif

    fifo_sdp_ram #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_BITS (ADDR_BITS)
    ) u_ram (
        .clk    (clk),
        .wr_en  (wr_en),
        .wr_addr(wr_ptr),
        .wr_data(data_in),
        .rd_en  (ram_rd_en),
        .rd_addr(ram_rd_addr),
        .rd_data(ram_q)
    );

endmodule

// File: doc/sync_fifo.md
SYNC_FIFO -- requirements
Module: sync_fifo

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, word width in bits.
REQ-002 SHALL have parameter ADDR_BITS, default 10; depth DEPTH = 2^ADDR_BITS words.
REQ-003 SHALL have parameter AFULL_THRESH, default DEPTH-4, almost_full level in words.
REQ-004 SHALL have parameter AEMPTY_THRESH, default 4, almost_empty level in words.
REQ-005 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-006 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-007 SHALL have port flush  input  1  synchronous clear of contents.
REQ-008 SHALL have port wr_req  input  1  write request.
REQ-009 SHALL have port data_in  input  DATA_WIDTH  write data.
REQ-010 SHALL have port rd_req  input  1  read request.
REQ-011 SHALL have port data_out  output  DATA_WIDTH  read data.
REQ-012 SHALL have port data_valid  output  1  data_out holds a newly read word.
REQ-013 SHALL have ports full, empty, almost_full, almost_empty  output  1 each  status flags.
REQ-014 SHALL have port usedw  output  ADDR_BITS+1  stored word count, 0..DEPTH.
REQ-015 SHALL have ports overflow, underflow  output  1 each  rejected-request pulses.

Function
REQ-016 Write SHALL be accepted iff wr_req && !full; word stored at wr_ptr, wr_ptr increments mod DEPTH.
REQ-017 Read SHALL be accepted iff rd_req && !empty; rd_ptr increments mod DEPTH.
REQ-018 Pointers SHALL wrap DEPTH-1 -> 0 with no loss or duplication of data.
REQ-019 usedw SHALL be registered: +1 on write only, -1 on read only, unchanged on both or neither.
REQ-020 full SHALL equal (usedw == DEPTH); empty SHALL equal (usedw == 0), both registered with usedw.
REQ-021 almost_full SHALL equal (usedw >= AFULL_THRESH); almost_empty SHALL equal (usedw <= AEMPTY_THRESH).
REQ-022 When full, wr_req SHALL be rejected even with a simultaneous accepted read.
REQ-023 When empty, rd_req SHALL be rejected even with a simultaneous accepted write.
REQ-024 overflow SHALL pulse one cycle, the cycle after wr_req && full; underflow likewise for rd_req && empty.
REQ-025 Accepted simultaneous read and write at 0 < usedw < DEPTH SHALL both complete; usedw unchanged.
REQ-026 flush SHALL zero pointers, usedw, data_valid, overflow and underflow next cycle; it overrides wr_req/rd_req that cycle; memory contents are not cleared.

Reset
REQ-027 rst_n low SHALL asynchronously set pointers 0, usedw 0, empty 1, almost_empty 1, full 0, almost_full 0, data_out 0, data_valid 0, overflow 0, underflow 0.
REQ-028 Reset mid-operation SHALL discard all stored words; first accepted write after release is the first word read.
REQ-029 Memory array SHALL NOT be reset.

Configuration
REQ-030 Macro SYNC_FIFO_FWFT_EN SHALL select first-word-fall-through mode.
REQ-031 Without it: data_out registered, valid 1 cycle after accepted read, data_valid a 1-cycle pulse per read; data_out holds between reads.
REQ-032 With it: data_out presents head word while !empty, data_valid = !empty; accepted read advances to next word the following cycle; first write reaches data_out 2 cycles after acceptance; empty, usedw and flags count the head word.

Structure
REQ-033 Package fifo_pkg SHALL hold depth/count-width helper constants and the flag-threshold defaults.
REQ-034 Storage SHALL be sub-module fifo_sdp_ram (simple dual-port, 1 write port, 1 registered read port, no reset).
REQ-035 Pointer, count, flag and output control SHALL reside in sync_fifo.

Verification
REQ-036 DEPTH=16: 16 writes 0x0001..0x0010, no reads -> full=1, usedw=16, almost_full=1 from usedw 12; 17th wr_req -> overflow pulse, usedw stays 16.
REQ-037 Then 16 reads -> data_out 0x0001..0x0010 in order (latency per mode), empty=1; extra rd_req -> underflow pulse, data_out unchanged.
REQ-038 Wrap: 40 interleaved writes/reads with usedw 3..10 -> read sequence equals write sequence, pointers wrap twice.
REQ-039 Simultaneous wr_req/rd_req at usedw=0, 8, 16 -> usedw becomes 1, 8, 15 respectively.
REQ-040 rst_n low mid-burst at usedw=9 -> outputs at reset values immediately; write 0xBEEF, read -> 0xBEEF.
REQ-041 flush with usedw=5 and wr_req=1 -> usedw=0, empty=1 next cycle, written word discarded.
